// File: rtl/usb_tx_if.sv
// Bus bundle between the packet-buffer/CPU side and the USB transmitter.
// The master side requests packets and supplies buffer words; the slave side
// (usb_tx) fetches words and drives the D+/D- pads.
interface usb_tx_if #(
    parameter int USB_PACKET_BUFFER_SIZE = 1024
);
    localparam int COUNT_W = $clog2(USB_PACKET_BUFFER_SIZE) + 1;
    localparam int ADDR_W  = $clog2(USB_PACKET_BUFFER_SIZE / 4);

    logic               start;
    logic [COUNT_W-1:0] byte_count;
    logic [ADDR_W-1:0]  packet_buffer_address;
    logic [31:0]        packet_buffer_read_value;
    logic               usb_d_p_out;
    logic               usb_d_n_out;
    logic               usb_output_enable;
    logic               busy;
    logic               done;

    modport master (
        output start, byte_count, packet_buffer_read_value,
        input  packet_buffer_address, usb_d_p_out, usb_d_n_out,
               usb_output_enable, busy, done
    );

    modport slave (
        input  start, byte_count, packet_buffer_read_value,
        output packet_buffer_address, usb_d_p_out, usb_d_n_out,
               usb_output_enable, busy, done
    );
endinterface

// File: rtl/usb_tx.sv
// Full-speed USB transmitter: SYNC, bit-stuffed NRZI payload from the packet
// buffer, EOP. Four clock48 cycles per line symbol; every symbol decision is
// made on the last clock (phase 3) of the symbol currently on the wire.
module usb_tx #(
    parameter int USB_PACKET_BUFFER_SIZE = 1024
) (
    input logic   clock48,
    input logic   reset,
    usb_tx_if.slave bus
);
    localparam int COUNT_W = $clog2(USB_PACKET_BUFFER_SIZE) + 1;
    localparam int ADDR_W  = $clog2(USB_PACKET_BUFFER_SIZE / 4);
    localparam int BITS_W  = COUNT_W + 3;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    state_t              state, state_next;
    logic [1:0]          phase, phase_next;
    logic [2:0]          sym_cnt, sym_cnt_next;
    logic [2:0]          stuff_cnt, stuff_cnt_next;
    logic                line_j, line_j_next;
    logic [BITS_W-1:0]   bits_left, bits_left_next;
    logic [4:0]          word_bits_left, word_bits_left_next;
    logic [31:0]         shift_word, shift_word_next;
    logic [31:0]         next_word;
    logic [ADDR_W-1:0]   address, address_next;
    logic                done_q, done_next;
    logic                take_data;
    logic                data_bit;

    // Next-state and datapath decisions; a new symbol is chosen only at phase 3.
    always_comb begin
        state_next          = state;
        phase_next          = (state == IDLE) ? 2'd0 : phase + 2'd1;
        sym_cnt_next        = sym_cnt;
        stuff_cnt_next      = stuff_cnt;
        line_j_next         = line_j;
        bits_left_next      = bits_left;
        word_bits_left_next = word_bits_left;
        shift_word_next     = shift_word;
        address_next        = address;
        done_next           = 1'b0;
        take_data           = 1'b0;
        data_bit            = (word_bits_left == 5'd0) ? next_word[0] : shift_word[0];

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next          = SYNC;
                    bits_left_next      = {bus.byte_count, 3'b000};
                    address_next        = '0;
                    sym_cnt_next        = 3'd0;
                    stuff_cnt_next      = 3'd0;
                    word_bits_left_next = 5'd0;
                    line_j_next         = 1'b0;
                end
            end
            SYNC: begin
                if (phase == 2'd3) begin
                    if (sym_cnt == 3'd7) begin
                        if (bits_left == '0) begin
                            state_next   = EOP_SE0;
                            sym_cnt_next = 3'd0;
                        end else begin
                            state_next = DATA;
                            take_data  = 1'b1;
                        end
                    end else begin
                        sym_cnt_next = sym_cnt + 3'd1;
                        if (sym_cnt == 3'd6) begin
                            stuff_cnt_next = stuff_cnt + 3'd1;
                        end else begin
                            line_j_next    = ~line_j;
                            stuff_cnt_next = 3'd0;
                        end
                    end
                end
            end
            DATA: begin
                if (phase == 2'd3) begin
                    if (stuff_cnt == 3'd6) begin
                        line_j_next    = ~line_j;
                        stuff_cnt_next = 3'd0;
                    end else if (bits_left != '0) begin
                        take_data = 1'b1;
                    end else begin
                        state_next   = EOP_SE0;
                        sym_cnt_next = 3'd0;
                    end
                end
            end
            EOP_SE0: begin
                if (phase == 2'd3) begin
                    if (sym_cnt == 3'd1) begin
                        state_next  = EOP_J;
                        line_j_next = 1'b1;
                    end else begin
                        sym_cnt_next = sym_cnt + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (phase == 2'd3) begin
                    state_next  = IDLE;
                    done_next   = 1'b1;
                    line_j_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (take_data) begin
            bits_left_next = bits_left - 1'b1;
            if (data_bit) begin
                stuff_cnt_next = stuff_cnt + 3'd1;
            end else begin
                stuff_cnt_next = 3'd0;
                line_j_next    = ~line_j;
            end
            if (word_bits_left == 5'd0) begin
                shift_word_next     = {1'b0, next_word[31:1]};
                word_bits_left_next = 5'd31;
                address_next        = address + 1'b1;
            end else begin
                shift_word_next     = {1'b0, shift_word[31:1]};
                word_bits_left_next = word_bits_left - 5'd1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock48) begin
        if (reset) begin
            state          <= IDLE;
            phase          <= 2'd0;
            sym_cnt        <= 3'd0;
            stuff_cnt      <= 3'd0;
            line_j         <= 1'b1;
            bits_left      <= '0;
            word_bits_left <= 5'd0;
            shift_word     <= '0;
            address        <= '0;
            done_q         <= 1'b0;
        end else begin
            state          <= state_next;
            phase          <= phase_next;
            sym_cnt        <= sym_cnt_next;
            stuff_cnt      <= stuff_cnt_next;
            line_j         <= line_j_next;
            bits_left      <= bits_left_next;
            word_bits_left <= word_bits_left_next;
            shift_word     <= shift_word_next;
            address        <= address_next;
            done_q         <= done_next;
        end
    end

    // Register the RAM output so the next word is ready well before it is needed.
    always_ff @(posedge clock48) begin
        if (reset) begin
            next_word <= '0;
        end else begin
            next_word <= bus.packet_buffer_read_value;
        end
    end

    assign bus.packet_buffer_address = address;
    assign bus.usb_output_enable     = (state != IDLE);
    assign bus.busy                  = (state != IDLE);
    assign bus.done                  = done_q;
    assign bus.usb_d_p_out = (state == IDLE) || (state == EOP_J) ||
                             (((state == SYNC) || (state == DATA)) && line_j);
    assign bus.usb_d_n_out = ((state == SYNC) || (state == DATA)) && !line_j;
endmodule
